sdram_arb: RTL and testbench



---
 rtl/sdram_arb_pkg.sv | 24 ++
 rtl/sdram_arb_prio.sv | 28 ++
 rtl/sdram_arb.sv | 174 +++++++++++++++++
 tb/tb_sdram_arb.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and default timing constants for the sdram host-port arbiter.
package sdram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE,
    GAP
  } arb_state_t;

  typedef enum logic [1:0] {
    REQ_LD,
    REQ_CPU,
    REQ_DMA
  } req_id_t;

  localparam int unsigned DEF_SLOT_CYCLES = 16;
  localparam int unsigned DEF_GAP_CYCLES  = 2;
  localparam int unsigned DEF_DMA_MAXWAIT = 3;
  localparam int unsigned ADDR_W          = 25;
  localparam int unsigned DATA_W          = 8;

endpackage

// File: rtl/sdram_arb_prio.sv
// Fixed-priority grant (ld > cpu > dma) with a starvation override for dma.
module sdram_arb_prio
  import sdram_arb_pkg::*;
#(
  parameter int unsigned DMA_MAXWAIT = DEF_DMA_MAXWAIT
) (
  input  logic       i_ld_req,
  input  logic       i_cpu_req,
  input  logic       i_dma_req,
  input  logic [1:0] i_dma_wait,
  output req_id_t    o_grant,
  output logic       o_valid
);

  logic w_dma_starved;

  assign w_dma_starved = i_dma_req && (i_dma_wait == 2'(DMA_MAXWAIT));

  always_comb begin
    o_valid = i_ld_req | i_cpu_req | i_dma_req;
    o_grant = REQ_LD;
    if (w_dma_starved)  o_grant = REQ_DMA;
    else if (i_ld_req)  o_grant = REQ_LD;
    else if (i_cpu_req) o_grant = REQ_CPU;
    else if (i_dma_req) o_grant = REQ_DMA;
  end

endmodule

// File: rtl/sdram_arb.sv
// Three-way arbiter/sequencer turning ld/cpu/dma requests into fixed-length
// sd_rd/sd_we slots on the sdram host port.
module sdram_arb
  import sdram_arb_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES = DEF_SLOT_CYCLES,
  parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int unsigned DMA_MAXWAIT = DEF_DMA_MAXWAIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_req,
  input  logic              cpu_req,
  input  logic              dma_req,
  input  logic              ld_we,
  input  logic              cpu_we,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] ld_din,
  input  logic [DATA_W-1:0] cpu_din,
  input  logic [DATA_W-1:0] dma_din,
  output logic              ld_ack,
  output logic              cpu_ack,
  output logic              dma_ack,
  output logic [DATA_W-1:0] ld_dout,
  output logic [DATA_W-1:0] cpu_dout,
  output logic [DATA_W-1:0] dma_dout,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [DATA_W-1:0] sd_din,
  output logic              sd_we,
  output logic              sd_rd,
  input  logic [DATA_W-1:0] sd_dout
);

  localparam int unsigned CNT_W =
    $clog2((SLOT_CYCLES > GAP_CYCLES) ? SLOT_CYCLES : GAP_CYCLES) + 1;

  arb_state_t        r_state, w_next;
  req_id_t           r_idx, w_grant;
  logic              w_valid;
  logic [1:0]        r_dma_wait;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr, r_sd_addr, w_addr;
  logic [DATA_W-1:0] r_din, r_sd_din, w_din;
  logic              w_we;
  logic              r_sd_we, r_sd_rd;
  logic [2:0]        r_ack;
  logic [DATA_W-1:0] r_ld_dout, r_cpu_dout, r_dma_dout;

  sdram_arb_prio #(
    .DMA_MAXWAIT(DMA_MAXWAIT)
  ) u_prio (
    .i_ld_req  (ld_req),
    .i_cpu_req (cpu_req),
    .i_dma_req (dma_req),
    .i_dma_wait(r_dma_wait),
    .o_grant   (w_grant),
    .o_valid   (w_valid)
  );

  always_comb begin
    w_addr = ld_addr;
    w_din  = ld_din;
    w_we   = ld_we;
    case (w_grant)
      REQ_CPU: begin w_addr = cpu_addr; w_din = cpu_din; w_we = cpu_we; end
      REQ_DMA: begin w_addr = dma_addr; w_din = dma_din; w_we = dma_we; end
      default: ;
    endcase
  end

  // WAIT tests the count before decrementing (SLOT_CYCLES high cycles), while
  // GAP leaves as the count reaches zero, giving one op per SLOT+GAP+2 cycles.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_valid) w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (r_cnt == '0) w_next = DONE;
      DONE:    w_next = GAP;
      GAP:     if (r_cnt <= CNT_W'(1)) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx      <= REQ_LD;
      r_dma_wait <= '0;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_din      <= '0;
      r_sd_addr  <= '0;
      r_sd_din   <= '0;
      r_sd_we    <= 1'b0;
      r_sd_rd    <= 1'b0;
      r_ack      <= '0;
      r_ld_dout  <= '0;
      r_cpu_dout <= '0;
      r_dma_dout <= '0;
    end else begin
      r_ack <= '0;

      if (!dma_req) begin
        r_dma_wait <= '0;
      end else if (r_state == IDLE && w_valid) begin
        if (w_grant == REQ_DMA)   r_dma_wait <= '0;
        else if (r_dma_wait != '1) r_dma_wait <= r_dma_wait + 2'd1;
      end

      case (r_state)
        IDLE: if (w_valid) begin
          r_idx  <= w_grant;
          r_addr <= w_addr;
          r_din  <= w_din;
          r_we   <= w_we;
        end
        ISSUE: begin
          r_sd_addr <= r_addr;
          r_sd_din  <= r_din;
          r_sd_we   <= r_we;
          r_sd_rd   <= ~r_we;
          r_cnt     <= CNT_W'(SLOT_CYCLES - 1);
        end
        WAIT: if (r_cnt == '0) begin
          // Strobe drop, ack and data capture are registered together so
          // they all appear in the DONE cycle.
          r_sd_we <= 1'b0;
          r_sd_rd <= 1'b0;
          case (r_idx)
            REQ_CPU: begin
              r_ack[1] <= 1'b1;
              if (!r_we) r_cpu_dout <= sd_dout;
            end
            REQ_DMA: begin
              r_ack[2] <= 1'b1;
              if (!r_we) r_dma_dout <= sd_dout;
            end
            default: begin
              r_ack[0] <= 1'b1;
              if (!r_we) r_ld_dout <= sd_dout;
            end
          endcase
        end else begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
        DONE: r_cnt <= CNT_W'(GAP_CYCLES - 1);
        GAP:  if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign ld_ack   = r_ack[0];
  assign cpu_ack  = r_ack[1];
  assign dma_ack  = r_ack[2];
  assign ld_dout  = r_ld_dout;
  assign cpu_dout = r_cpu_dout;
  assign dma_dout = r_dma_dout;
  assign sd_addr  = r_sd_addr;
  assign sd_din   = r_sd_din;
  assign sd_we    = r_sd_we;
  assign sd_rd    = r_sd_rd;

endmodule

// File: tb/tb_sdram_arb.sv
// Directed + randomised bench for sdram_arb with a byte-memory sdram model
// and an ack-ordered scoreboard.
module tb_sdram_arb;

  localparam int SLOT = 16;
  localparam int GAP  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_req, cpu_req, dma_req;
  logic        ld_we, cpu_we, dma_we;
  logic [24:0] ld_addr, cpu_addr, dma_addr;
  logic [7:0]  ld_din, cpu_din, dma_din;
  logic        ld_ack, cpu_ack, dma_ack;
  logic [7:0]  ld_dout, cpu_dout, dma_dout;
  logic [24:0] sd_addr;
  logic [7:0]  sd_din;
  logic        sd_we, sd_rd;
  logic [7:0]  sd_dout = '0;

  sdram_arb #(.SLOT_CYCLES(SLOT), .GAP_CYCLES(GAP), .DMA_MAXWAIT(3)) dut (
    .clk(clk), .reset(reset),
    .ld_req(ld_req), .cpu_req(cpu_req), .dma_req(dma_req),
    .ld_we(ld_we), .cpu_we(cpu_we), .dma_we(dma_we),
    .ld_addr(ld_addr), .cpu_addr(cpu_addr), .dma_addr(dma_addr),
    .ld_din(ld_din), .cpu_din(cpu_din), .dma_din(dma_din),
    .ld_ack(ld_ack), .cpu_ack(cpu_ack), .dma_ack(dma_ack),
    .ld_dout(ld_dout), .cpu_dout(cpu_dout), .dma_dout(dma_dout),
    .sd_addr(sd_addr), .sd_din(sd_din), .sd_we(sd_we), .sd_rd(sd_rd),
    .sd_dout(sd_dout)
  );

  always #5 clk = ~clk;

  typedef struct { int id; logic [7:0] dout; } exp_t;
  exp_t sb[$];
  bit   sb_en = 1'b1;

  int checks = 0, errors = 0, cyc = 0;
  int ack_cnt[4], ack_cyc[3], grants[4];
  int both_viol = 0, addr_viol = 0, multi_ack = 0, we_cycles = 0;
  int high_run = 0, high_run_last = 0, low_run = 0, low_run_last = 0;
  logic        prev_act = 1'b0;
  logic [24:0] prev_addr = '0;
  logic [7:0]  wr_din_last = '0;
  logic [7:0]  mem [logic [24:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_rd(input logic [24:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] dout_of(input int i);
    case (i)
      0:       return ld_dout;
      1:       return cpu_dout;
      default: return dma_dout;
    endcase
  endfunction

  always @(posedge clk) cyc++;

  // sdram model: writes land while sd_we is high, read data follows sd_addr.
  always @(negedge clk) begin
    if (sd_we) mem[sd_addr] = sd_din;
    sd_dout = model_rd(sd_addr);
  end

  always @(negedge clk) begin
    logic       act;
    logic [2:0] av;
    exp_t       e;
    act = sd_rd | sd_we;
    av  = {dma_ack, cpu_ack, ld_ack};
    if (sd_rd && sd_we) both_viol++;
    if ($countones(av) > 1) multi_ack++;
    if (act && prev_act && sd_addr !== prev_addr) addr_viol++;
    if (sd_we) we_cycles++;
    if (act && !prev_act) begin
      grants[sd_addr[24:23]]++;
      low_run_last = low_run;
      high_run = 1;
      if (sd_we) wr_din_last = sd_din;
    end else if (act) begin
      high_run++;
    end
    if (!act) begin
      if (prev_act) begin high_run_last = high_run; low_run = 1; end
      else low_run++;
    end
    prev_act  = act;
    prev_addr = sd_addr;
    for (int i = 0; i < 3; i++) begin
      if (av[i]) begin
        ack_cnt[i]++;
        ack_cnt[3]++;
        ack_cyc[i] = cyc;
        if (sb_en) begin
          check("sb_entry_for_ack", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("ack_id", i, e.id);
            check("ack_dout", dout_of(i), e.dout);
          end
        end
      end
    end
  end

  task automatic wait_ack(input int id, input int target, input string tag);
    int n = 0;
    while (ack_cnt[id] < target && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    check(tag, ack_cnt[id] >= target, 1);
  endtask

  task automatic raise(input int i);
    logic [24:0] a;
    logic        w;
    logic [7:0]  d;
    a = {i[1:0], 23'($urandom)};
    w = 1'($urandom_range(0, 1));
    d = 8'($urandom);
    case (i)
      0:       begin ld_addr  = a; ld_we  = w; ld_din  = d; ld_req  = 1'b1; end
      1:       begin cpu_addr = a; cpu_we = w; cpu_din = d; cpu_req = 1'b1; end
      default: begin dma_addr = a; dma_we = w; dma_din = d; dma_req = 1'b1; end
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, a0, base, we0;
    int pend[3], issued[3], bacq[3], bgr[3];

    reset = 1'b1;
    {ld_req, cpu_req, dma_req} = '0;
    {ld_we, cpu_we, dma_we}    = '0;
    ld_addr = '0; cpu_addr = '0; dma_addr = '0;
    ld_din  = '0; cpu_din  = '0; dma_din  = '0;
    mem[25'h001234] = 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sd_rd", sd_rd, 0);
    check("rst_sd_we", sd_we, 0);
    check("rst_acks", {ld_ack, cpu_ack, dma_ack}, 0);
    check("rst_sd_addr", sd_addr, 0);
    check("rst_cpu_dout", cpu_dout, 0);
    reset = 1'b0;

    // Single CPU read
    @(posedge clk); #1;
    cpu_addr = 25'h001234; cpu_we = 1'b0; cpu_req = 1'b1;
    c0 = cyc; we0 = we_cycles;
    sb.push_back('{1, 8'h5A});
    wait_ack(1, 1, "cpu_read_ack_timeout");
    cpu_req = 1'b0;
    check("cpu_read_latency", ack_cyc[1] - c0, SLOT + 2);
    check("sd_rd_high_cycles", high_run_last, SLOT);
    check("cpu_dout_5a", cpu_dout, 8'h5A);
    check("sd_we_never_high", we_cycles - we0, 0);

    // ld write and CPU read of the same byte raised together
    ld_addr = 25'h004000; ld_we = 1'b1; ld_din = 8'hA5; ld_req = 1'b1;
    cpu_addr = 25'h004000; cpu_we = 1'b0; cpu_req = 1'b1;
    sb.push_back('{0, 8'h00});
    sb.push_back('{1, 8'hA5});
    we0 = we_cycles;
    wait_ack(0, 1, "ld_write_ack_timeout");
    ld_req = 1'b0;
    check("ld_write_din", wr_din_last, 8'hA5);
    check("ld_write_we_cycles", we_cycles - we0, SLOT);
    check("cpu_not_acked_first", ack_cnt[1], 1);
    wait_ack(1, 2, "cpu_after_ld_timeout");
    cpu_req = 1'b0;
    check("ld_to_cpu_ack_spacing", ack_cyc[1] - ack_cyc[0], SLOT + GAP + 2);

    // CPU held high vs DMA: three CPU grants then DMA, twice
    cpu_addr = 25'h001234; cpu_we = 1'b0; cpu_req = 1'b1;
    dma_addr = 25'h003001; dma_we = 1'b0; dma_req = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) sb.push_back('{1, 8'h5A});
      sb.push_back('{2, model_rd(25'h003001)});
    end
    base = ack_cnt[3]; a0 = ack_cnt[2];
    wait_ack(3, base + 8, "dma_starvation_timeout");
    cpu_req = 1'b0; dma_req = 1'b0;
    check("dma_grants", ack_cnt[2] - a0, 2);
    check("dma_dout", dma_dout, 8'h3D);

    // Back-to-back ld writes, then read one back
    ld_we = 1'b1; ld_addr = 25'h004001; ld_din = 8'h11; ld_req = 1'b1;
    base = ack_cnt[0];
    for (int k = 0; k < 3; k++) sb.push_back('{0, 8'h00});
    wait_ack(0, base + 1, "b2b_ack1_timeout");
    a0 = ack_cyc[0];
    ld_addr = 25'h004002; ld_din = 8'h22;
    wait_ack(0, base + 2, "b2b_ack2_timeout");
    check("b2b_spacing_1", ack_cyc[0] - a0, SLOT + GAP + 2);
    check("b2b_low_min", low_run_last >= GAP + 1, 1);
    a0 = ack_cyc[0];
    ld_addr = 25'h004003; ld_din = 8'h33;
    wait_ack(0, base + 3, "b2b_ack3_timeout");
    check("b2b_spacing_2", ack_cyc[0] - a0, SLOT + GAP + 2);
    check("b2b_we_high", high_run_last, SLOT);
    ld_we = 1'b0; ld_addr = 25'h004002;
    sb.push_back('{0, 8'h22});
    wait_ack(0, base + 4, "ld_readback_timeout");
    ld_req = 1'b0;
    check("ld_readback", ld_dout, 8'h22);
    check("addr_stable_while_active", addr_viol, 0);

    // Reset in the middle of a CPU slot
    cpu_addr = 25'h002000; cpu_we = 1'b0; cpu_req = 1'b1;
    c0 = cyc; base = ack_cnt[3];
    while (cyc < c0 + 9) @(negedge clk);
    #1;
    check("sd_rd_before_reset", sd_rd, 1);
    reset = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;
    check("reset_sd_rd", sd_rd, 0);
    check("reset_cpu_ack", cpu_ack, 0);
    check("reset_cpu_dout", cpu_dout, 0);
    check("reset_ld_dout", ld_dout, 0);
    check("reset_sd_addr", sd_addr, 0);
    reset = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    check("no_ack_after_reset", ack_cnt[3] - base, 0);
    cpu_req = 1'b1;
    c0 = cyc; base = ack_cnt[1];
    sb.push_back('{1, 8'h3C});
    wait_ack(1, base + 1, "post_reset_ack_timeout");
    cpu_req = 1'b0;
    check("post_reset_latency", ack_cyc[1] - c0, SLOT + 2);

    // Randomised traffic with disjoint address regions per requester
    sb_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pend[i] = 0; issued[i] = 0; bacq[i] = ack_cnt[i]; bgr[i] = grants[i];
    end
    for (int n = 0; n < 6200; n++) begin
      @(negedge clk); #1;
      if (ld_ack)  begin ld_req  = 1'b0; pend[0] = 0; end
      if (cpu_ack) begin cpu_req = 1'b0; pend[1] = 0; end
      if (dma_ack) begin dma_req = 1'b0; pend[2] = 0; end
      for (int i = 0; i < 3; i++) begin
        if (n < 6000 && pend[i] == 0 && $urandom_range(0, 7) == 0) begin
          raise(i);
          pend[i] = 1;
          issued[i]++;
        end
      end
      if (n >= 6000 && (pend[0] | pend[1] | pend[2]) == 0) break;
    end
    check("random_drained", pend[0] | pend[1] | pend[2], 0);
    for (int i = 0; i < 3; i++) begin
      check("random_acks_vs_issued", ack_cnt[i] - bacq[i], issued[i]);
      check("random_grants_vs_acks", grants[i] - bgr[i], ack_cnt[i] - bacq[i]);
    end
    check("rd_we_never_both", both_viol, 0);
    check("single_ack_per_cycle", multi_ack, 0);
    check("addr_stable_final", addr_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
